elevator_dispatch_fsm: RTL
==========================

// Module: elevator_dispatch_fsm
// PURPOSE
//  Consumer end of the 16x4 elevator request queue. Reads the queue head (slot 0), drives the car
//  floor by floor to the requested floor and holds the door open. It then pulses shift to pop the
//  request. Sits between the request queue and the motor/door drivers; the queue producer is the
//  button logic.
// PARAMETERS
//  NUM_FLOORS   15  highest valid floor code; valid floors are 1..NUM_FLOORS (max 15)
//  HOME_FLOOR   1   car floor after reset
//  FLOOR_TICKS  4   clk cycles to travel one floor (>=1)
//  DOOR_TICKS   8   clk cycles the door stays open (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  head_floor   in   4  queue slot 0 (queue saidaSecundaria with addrSecundario tied 0); 0 = empty
//  door_block   in   1  door obstruction sensor (used only with DOOR_SENSOR_EN)
//  shift        out  1  one-cycle pop strobe to queue shift input
//  floor        out  4  current car floor
//  motor_up     out  1  car moving up
//  motor_down   out  1  car moving down
//  door_open    out  1  door open command
//  busy         out  1  state != IDLE
//  req_err      out  1  one-cycle pulse: head_floor > NUM_FLOORS, request discarded
// BEHAVIOUR
//  - Reset: state=IDLE, floor=HOME_FLOOR, timer=0, target=0; all other outputs 0. Reset is
//    asynchronous and aborts any move or door cycle at once. No queue pop is issued.
//  - IDLE: if head_floor!=0, latch target<=head_floor and go to FETCH; else stay.
//  - FETCH (1 cycle), exits checked in this order:
//      target>NUM_FLOORS -> POP with req_err=1
//      target==floor     -> DOOR
//      target>floor      -> UP
//      else              -> DOWN
//  - UP/DOWN: motor_up/motor_down=1 throughout. The timer loads FLOOR_TICKS on entry and on each
//    floor step. When the timer expires, floor+=1 (or -=1). If the new floor==target -> DOOR,
//    else reload and stay. Motor outputs are never both 1.
//  - DOOR: door_open=1. The timer loads DOOR_TICKS on entry; on expiry -> POP.
//  - POP: shift=1 for exactly one cycle, then SETTLE.
//  - SETTLE: 1 cycle, no outputs. It absorbs the queue's shift write so the stale head is never
//    re-fetched. Then -> IDLE.
//  - Latency: a same-floor request gives IDLE->FETCH->DOOR. door_open is first seen 2 cycles after
//    head_floor becomes nonzero.
//  - A move of N floors takes N*FLOOR_TICKS cycles in UP/DOWN.
//  - target is latched once in IDLE. head_floor changes during service are ignored until SETTLE
//    completes. The queue is FIFO, so slot 0 is stable.
//  - floor stays within 1..NUM_FLOORS by construction; the floor arithmetic is 4-bit and never wraps.
//  - The shift pulse and the queue producer's write-to-tail may occur in the same cycle; the queue
//    owns that ordering and this block places no constraint on it.
// CONFIGURATION
//  DOOR_SENSOR_EN defined:
//    - In DOOR, door_block=1 reloads the timer to DOOR_TICKS every cycle it is high.
//    - The door closes only DOOR_TICKS cycles after door_block falls.
//    - A door_block that is stuck high keeps the FSM in DOOR indefinitely; this is intended.
//  DOOR_SENSOR_EN undefined: door_block is ignored; the door time is always exactly DOOR_TICKS.
// STRUCTURE
//  - Package elevator_pkg holds:
//      state encoding: IDLE, FETCH, UP, DOWN, DOOR, POP, SETTLE
//      FLOOR_W=4
//      EMPTY_SLOT=4'd0
//  - One sub-module, tick_timer: a loadable down-counter with load/value/expired. It is shared by
//    the travel and door timing, since only one of them is active at a time.
// TESTING
//  - Reset mid-move: assert rst_n=0 while in UP at floor 3 -> outputs 0 immediately, floor=1,
//    no shift seen.
//  - Floor 1, head=3, FLOOR_TICKS=4:
//      motor_up high 8 cycles
//      floor 1->2->3
//      door_open 8 cycles
//      then one shift pulse
//      busy falls 2 cycles after shift.
//  - Floor 5, head=2 -> motor_down 12 cycles, floor ends at 2, exactly one shift.
//  - Floor 1, head=1 -> no motor activity; door_open asserted 2 cycles after the request,
//    then shift.
//  - Invalid request: with NUM_FLOORS=8, head=12 -> req_err and shift in the same cycle (POP),
//    floor unchanged, no door.
//  - Back-to-back: queue {3,1} -> serve 3, then 1. The second fetch occurs only after SETTLE,
//    and exactly 2 shifts are seen.
//  - DOOR_SENSOR_EN: hold door_block for 5 cycles mid-door -> door_open lasts 8 cycles after
//    door_block falls. Without the macro the door time stays exactly 8 cycles.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator dispatch block.
//   state_t    : dispatch FSM state encoding
//   FLOOR_W    : width of floor codes (queue slot width)
//   TICK_W     : width of the shared travel/door tick timer
//   EMPTY_SLOT : queue slot value meaning "no request"
package elevator_pkg;

  localparam int FLOOR_W = 4;
  localparam int TICK_W  = 8;

  localparam logic [FLOOR_W-1:0] EMPTY_SLOT = 4'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    UP     = 3'd2,
    DOWN   = 3'd3,
    DOOR   = 3'd4,
    POP    = 3'd5,
    SETTLE = 3'd6
  } state_t;

endpackage

// File: rtl/elevator_dispatch_fsm_tick_timer.sv
// tick_timer: loadable down-counter shared by travel and door timing.
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset (count clears to 0)
//   load_i     in  load value_i this cycle (wins over counting)
//   value_i    in  tick count to load
//   expired_o  out the current cycle is the last tick of the loaded interval
// A load of N gives N cycles (N, N-1, ..., 1) with expired_o high on the
// last one. The counter rests at 0, which also reads as expired.
module tick_timer
  import elevator_pkg::*;
#(
  parameter int W = TICK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q <= W'(1));

endmodule

// File: rtl/elevator_dispatch_fsm.sv
// elevator_dispatch_fsm: consumer end of the elevator request queue.
// Reads queue slot 0, drives the car floor by floor to the requested floor,
// holds the door open, then pops the request with a one-cycle shift.
//   clk         in  system clock, rising edge
//   rst_n       in  asynchronous active-low reset
//   head_floor  in  queue slot 0; 0 = empty
//   door_block  in  door obstruction sensor (only with DOOR_SENSOR_EN)
//   shift       out one-cycle pop strobe to the queue
//   floor       out current car floor
//   motor_up    out car moving up
//   motor_down  out car moving down
//   door_open   out door open command
//   busy        out FSM not in IDLE
//   req_err     out one-cycle pulse when a request above NUM_FLOORS is discarded
//   state_dbg   out current FSM state (debug observation)
// Handshake: no valid/ready pair here. A nonzero head_floor is a pending
// request; it is latched once in IDLE and acknowledged by exactly one shift
// pulse in POP. SETTLE then gives the queue one cycle to move its new head
// into slot 0 before head_floor is looked at again.
// Build option: define DOOR_SENSOR_EN to let door_block hold the door open.
module elevator_dispatch_fsm
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 15,
  parameter int HOME_FLOOR  = 1,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOOR_W-1:0] head_floor,
  input  logic               door_block,
  output logic               shift,
  output logic [FLOOR_W-1:0] floor,
  output logic               motor_up,
  output logic               motor_down,
  output logic               door_open,
  output logic               busy,
  output logic               req_err,
  output logic [2:0]         state_dbg
);

  localparam logic [FLOOR_W-1:0] MAX_FLOOR  = FLOOR_W'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] HOME       = FLOOR_W'(HOME_FLOOR);
  localparam logic [TICK_W-1:0]  TRAVEL_VAL = TICK_W'(FLOOR_TICKS);
  localparam logic [TICK_W-1:0]  DOOR_VAL   = TICK_W'(DOOR_TICKS);

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [FLOOR_W-1:0] target_q, target_d;

  logic               tmr_load;
  logic [TICK_W-1:0]  tmr_val;
  logic               tmr_expired;

  tick_timer #(.W(TICK_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_expired)
  );

`ifndef DOOR_SENSOR_EN
  logic unused_door_block;
  assign unused_door_block = door_block;
`endif

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    target_d   = target_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    shift      = 1'b0;
    motor_up   = 1'b0;
    motor_down = 1'b0;
    door_open  = 1'b0;
    req_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_floor != EMPTY_SLOT) begin
          target_d = head_floor;
          state_d  = FETCH;
        end
      end

      FETCH: begin
        if (target_q > MAX_FLOOR) begin
          state_d = POP;
        end else if (target_q == floor_q) begin
          state_d  = DOOR;
          tmr_load = 1'b1;
          tmr_val  = DOOR_VAL;
        end else if (target_q > floor_q) begin
          state_d  = UP;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_VAL;
        end else begin
          state_d  = DOWN;
          tmr_load = 1'b1;
          tmr_val  = TRAVEL_VAL;
        end
      end

      // On each floor step either arrive (door timing starts) or reload travel.
      UP, DOWN: begin
        motor_up   = (state_q == UP);
        motor_down = (state_q == DOWN);
        if (tmr_expired) begin
          floor_d  = (state_q == UP) ? floor_q + 1'b1 : floor_q - 1'b1;
          tmr_load = 1'b1;
          if (floor_d == target_q) begin
            state_d = DOOR;
            tmr_val = DOOR_VAL;
          end else begin
            tmr_val = TRAVEL_VAL;
          end
        end
      end

      DOOR: begin
        door_open = 1'b1;
`ifdef DOOR_SENSOR_EN
        // An obstruction restarts the full door interval; it must win over expiry.
        if (door_block) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_VAL;
        end else if (tmr_expired) begin
          state_d = POP;
        end
`else
        if (tmr_expired) begin
          state_d = POP;
        end
`endif
      end

      POP: begin
        shift   = 1'b1;
        req_err = (target_q > MAX_FLOOR);
        state_d = SETTLE;
      end

      SETTLE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      floor_q  <= HOME;
      target_q <= EMPTY_SLOT;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      target_q <= target_d;
    end
  end

  assign floor     = floor_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
